ghost_step_ctrl: RTL and testbench
==================================

Name: ghost_step_ctrl

Overview:
- Per-ghost movement sequencer that sits directly upstream of each ghost behaviour block (blinky and siblings).
- On every movement tick it:
  - fetches the three maze rows around the ghost from the synchronous maze-wall RAM,
  - presents them as the four neighbour words the behaviour block consumes,
  - samples the behaviour block's proposed next tile,
  - checks that tile for legality and commits it into the ghost position register.
- Its registered position is the currPos for the behaviour block and the source position for rendering and collision logic.

Parameters:
- START_POS, 10'd367, tile loaded on reset ({row 11, col 15}).
- CHECK_MOVES, 1, 1 = reject illegal proposals; 0 = commit next_pos_in unchecked.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- move_tick  in  1  single-cycle pulse requesting one ghost step
- load_pos  in  1  force position (spawn/respawn/level restart)
- load_val  in  10  position forced by load_pos
- mem_rd  out  1  maze RAM read strobe
- mem_addr  out  5  maze RAM row address
- mem_rdata  in  32  row word; bit[c]=1 means wall at column c; valid the cycle after mem_rd
- nbr_rows  out  4x32  [0]=row above, [1]=row below, [2]=current row (left), [3]=current row (right)
- nbr_valid  out  1  nbr_rows is complete; behaviour output is sampled this cycle
- next_pos_in  in  10  proposed tile from the behaviour block (combinational path)
- ghost_pos  out  10  registered ghost tile {row[9:5], col[4:0]}
- busy  out  1  step in progress
- step_done  out  1  one-cycle pulse when a step resolves
- overrun  out  1  sticky: move_tick arrived while busy
- illegal_move  out  1  sticky: a proposal was rejected

Behaviour:
- Reset values:
  - ghost_pos=START_POS.
  - nbr_rows all zero.
  - nbr_valid, busy, step_done, mem_rd, overrun, illegal_move all 0.
  - mem_addr=0.
  - State=IDLE.
- Position fields: row=pos[9:5], col=pos[4:0]. Row and column arithmetic is mod 32; wrap-around is the tunnel.
  - up = row-1 (0→31), down = row+1 (31→0).
  - left = col-1, right = col+1, with the same wrap.
- FSM states: IDLE, RD_UP, RD_CUR, RD_DN, CAP_DN, DECIDE.
- Step timing, counted from move_tick high in IDLE as cycle 0:
  - Cycle 1, RD_UP: mem_rd=1, mem_addr=up.
  - Cycle 2, RD_CUR: mem_addr=row; capture mem_rdata into nbr_rows[0].
  - Cycle 3, RD_DN: mem_addr=down; capture mem_rdata into nbr_rows[2] and nbr_rows[3].
  - Cycle 4, CAP_DN: mem_rd=0; capture mem_rdata into nbr_rows[1].
  - Cycle 5, DECIDE: nbr_valid=1 and step_done=1; next_pos_in is evaluated.
  - At the end of cycle 5: ghost_pos updates, then return to IDLE.
  - busy=1 in cycles 1–5.
  - Minimum tick spacing is 6 cycles.
- Legality, checked only when CHECK_MOVES=1. next_pos_in is legal iff:
  - it equals ghost_pos, or
  - it is one of the 4 wrapped neighbours of ghost_pos and the wall bit at the target is 0:
    - up target: nbr_rows[0][col]
    - down target: nbr_rows[1][col]
    - left target: nbr_rows[2][col-1]
    - right target: nbr_rows[3][col+1]
- Illegal proposal: ghost_pos holds, illegal_move is set, and step_done still pulses.
- move_tick while busy: the tick is ignored and overrun is set.
- Priority: load_pos beats everything.
  - Takes effect in any state: ghost_pos=load_val next cycle.
  - FSM returns to IDLE; nbr_valid=0; no step_done for an aborted step.
- move_tick and load_pos in the same IDLE cycle: load wins and the tick is dropped without setting overrun.
- Sticky flags clear only on reset.
- ghost_pos changes only at the end of DECIDE or on load; nbr_rows hold their values between steps.
- Reset mid-step: all outputs return to their reset values on the next edge; no step_done is produced.

Decomposition:
- ghost_pkg holds:
  - pos_t (10 bits) and the row/col field helpers (GRID_BITS=5, MAZE_W=32);
  - the step-FSM state enum;
  - NBR_UP/NBR_DN/NBR_L/NBR_R index constants;
  - START_POS constants for the four ghosts.
- One combinational sub-module: ghost_move_check.
  - Inputs: ghost_pos, next_pos_in, nbr_rows.
  - Output: legal.
  - Contains all wrap and wall-bit logic, so it can be tested on its own.

Test Plan:
1. Reset, with the RAM model returning all-zero rows → ghost_pos=367. Tick at cycle 0 → mem_addr sequence 10, 11, 12 in cycles 1–3; nbr_valid and step_done high only in cycle 5. With next_pos_in=368, ghost_pos=368 in cycle 6.
2. Wall check: row 11 word has bit 16 set, ghost_pos=367, next_pos_in=368 → ghost_pos stays 367, illegal_move=1, step_done=1. Repeat with next_pos_in=335 (up, row 10 clear) → ghost_pos=335.
3. Wrap-around: load_val={row 14, col 31}=479, tick, next_pos_in={row 14, col 0}=448, row 14 bit 0 clear → ghost_pos=448. Repeat with load_val=0, tick → mem_addr sequence 31, 0, 1.
4. Illegal jump: next_pos_in two tiles away (367→369) → held at 367 with illegal_move=1. Same proposal with CHECK_MOVES=0 → ghost_pos=369.
5. Overrun: second tick in cycle 3 → overrun=1; only one step_done; the step completes normally.
6. Load mid-step: load_pos=1, load_val=100 in cycle 3 → ghost_pos=100 next cycle; busy=0; no step_done. Reset in cycle 4 of a step → ghost_pos=367, all flags 0.

Source files
------------

// File: rtl/ghost_pkg.sv
// ghost_pkg: shared position types, step-FSM states and ghost spawn tiles
package ghost_pkg;
    localparam int GRID_BITS = 5;
    localparam int MAZE_W = 32;
    typedef logic [2*GRID_BITS-1:0] pos_t;
    typedef logic [GRID_BITS-1:0] coord_t;
    typedef logic [3:0][MAZE_W-1:0] nbr_t;
    typedef enum logic [2:0] {IDLE, RD_UP, RD_CUR, RD_DN, CAP_DN, DECIDE} step_state_e;
    localparam logic [1:0] NBR_UP = 2'd0;
    localparam logic [1:0] NBR_DN = 2'd1;
    localparam logic [1:0] NBR_L = 2'd2;
    localparam logic [1:0] NBR_R = 2'd3;
    localparam pos_t BLINKY_START = 10'd367;
    localparam pos_t PINKY_START = 10'd463;
    localparam pos_t INKY_START = 10'd461;
    localparam pos_t CLYDE_START = 10'd465;
    function automatic coord_t pos_row(input pos_t p);
        return p[2*GRID_BITS-1:GRID_BITS];
    endfunction
    function automatic coord_t pos_col(input pos_t p);
        return p[GRID_BITS-1:0];
    endfunction
    function automatic pos_t pos_make(input coord_t r, input coord_t c);
        return {r, c};
    endfunction
endpackage

// File: rtl/ghost_move_check.sv
// ghost_move_check: a proposal is legal if it stays put or steps to an open wrapped neighbour
module ghost_move_check
    import ghost_pkg::*;
(
    input  logic [2*GRID_BITS-1:0]   ghost_pos,
    input  logic [2*GRID_BITS-1:0]   next_pos_in,
    input  logic [3:0][MAZE_W-1:0]   nbr_rows,
    output logic                     legal
);
    coord_t r, c, cl, cr;
    always_comb begin
        r = pos_row(ghost_pos);
        c = pos_col(ghost_pos);
        cl = c - 5'd1;
        cr = c + 5'd1;
        legal = (next_pos_in == ghost_pos)
            || (next_pos_in == pos_make(r - 5'd1, c) && !nbr_rows[NBR_UP][c])
            || (next_pos_in == pos_make(r + 5'd1, c) && !nbr_rows[NBR_DN][c])
            || (next_pos_in == pos_make(r, cl) && !nbr_rows[NBR_L][cl])
            || (next_pos_in == pos_make(r, cr) && !nbr_rows[NBR_R][cr]);
    end
endmodule

// File: rtl/ghost_step_ctrl.sv
// ghost_step_ctrl: per-ghost step sequencer; fetches neighbour maze rows and commits checked moves
module ghost_step_ctrl
    import ghost_pkg::*;
#(
    parameter logic [9:0] START_POS = BLINKY_START,
    parameter bit CHECK_MOVES = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   move_tick,
    input  logic                   load_pos,
    input  logic [9:0]             load_val,
    output logic                   mem_rd,
    output logic [4:0]             mem_addr,
    input  logic [31:0]            mem_rdata,
    output logic [3:0][31:0]       nbr_rows,
    output logic                   nbr_valid,
    input  logic [9:0]             next_pos_in,
    output logic [9:0]             ghost_pos,
    output logic                   busy,
    output logic                   step_done,
    output logic                   overrun,
    output logic                   illegal_move
);
    step_state_e state_q, state_d;
    pos_t ghost_pos_q, ghost_pos_d;
    nbr_t nbr_rows_q, nbr_rows_d;
    coord_t mem_addr_q, mem_addr_d, row;
    logic mem_rd_q, mem_rd_d, nbr_valid_q, nbr_valid_d, step_done_q, step_done_d;
    logic busy_q, busy_d, overrun_q, overrun_d, illegal_move_q, illegal_move_d, legal;

    ghost_move_check u_check (
        .ghost_pos   (ghost_pos_q),
        .next_pos_in (next_pos_in),
        .nbr_rows    (nbr_rows_q),
        .legal       (legal)
    );

    always_comb begin
        row = pos_row(ghost_pos_q);
        state_d = state_q;
        ghost_pos_d = ghost_pos_q;
        nbr_rows_d = nbr_rows_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d = 1'b0;
        nbr_valid_d = 1'b0;
        step_done_d = 1'b0;
        busy_d = 1'b1;
        overrun_d = overrun_q | (move_tick && state_q != IDLE && !load_pos);
        illegal_move_d = illegal_move_q;
        if (load_pos) begin
            state_d = IDLE;
            ghost_pos_d = load_val;
            busy_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = move_tick;
                    mem_rd_d = move_tick;
                    state_d = move_tick ? RD_UP : IDLE;
                    mem_addr_d = move_tick ? row - 5'd1 : mem_addr_q;
                end
                RD_UP: begin
                    state_d = RD_CUR;
                    mem_rd_d = 1'b1;
                    mem_addr_d = row;
                end
                RD_CUR: begin
                    state_d = RD_DN;
                    mem_rd_d = 1'b1;
                    mem_addr_d = row + 5'd1;
                    nbr_rows_d[NBR_UP] = mem_rdata;
                end
                RD_DN: begin
                    state_d = CAP_DN;
                    nbr_rows_d[NBR_L] = mem_rdata;
                    nbr_rows_d[NBR_R] = mem_rdata;
                end
                CAP_DN: begin
                    state_d = DECIDE;
                    nbr_rows_d[NBR_DN] = mem_rdata;
                    nbr_valid_d = 1'b1;
                    step_done_d = 1'b1;
                end
                DECIDE: begin
                    state_d = IDLE;
                    busy_d = 1'b0;
                    ghost_pos_d = (!CHECK_MOVES || legal) ? next_pos_in : ghost_pos_q;
                    illegal_move_d = illegal_move_q | (CHECK_MOVES && !legal);
                end
                default: begin
                    state_d = IDLE;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ghost_pos_q <= START_POS;
            nbr_rows_q <= '0;
            mem_addr_q <= '0;
            mem_rd_q <= 1'b0;
            nbr_valid_q <= 1'b0;
            step_done_q <= 1'b0;
            busy_q <= 1'b0;
            overrun_q <= 1'b0;
            illegal_move_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ghost_pos_q <= ghost_pos_d;
            nbr_rows_q <= nbr_rows_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q <= mem_rd_d;
            nbr_valid_q <= nbr_valid_d;
            step_done_q <= step_done_d;
            busy_q <= busy_d;
            overrun_q <= overrun_d;
            illegal_move_q <= illegal_move_d;
        end
    end

    assign ghost_pos = ghost_pos_q;
    assign nbr_rows = nbr_rows_q;
    assign mem_addr = mem_addr_q;
    assign mem_rd = mem_rd_q;
    assign nbr_valid = nbr_valid_q;
    assign step_done = step_done_q;
    assign busy = busy_q;
    assign overrun = overrun_q;
    assign illegal_move = illegal_move_q;
endmodule

// File: tb/tb_ghost_step_ctrl.sv
// tb_ghost_step_ctrl: directed vector table plus multi-cycle sequences for ghost_step_ctrl
module tb_ghost_step_ctrl;
    import ghost_pkg::*;

    typedef struct {
        pos_t start;
        pos_t np;
        logic [31:0] up_w;
        logic [31:0] cur_w;
        logic [31:0] dn_w;
        pos_t exp_pos;
        logic exp_ill;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1, move_tick = 1'b0, load_pos = 1'b0;
    logic [9:0] load_val = '0, next_pos_in = '0;
    logic mem_rd, mem_rd_n;
    logic [4:0] mem_addr, mem_addr_n;
    logic [31:0] mem_rdata = '0, mem_rdata_n = '0;
    logic [3:0][31:0] nbr_rows, nbr_rows_n;
    logic nbr_valid, nbr_valid_n;
    logic [9:0] ghost_pos, ghost_pos_n;
    logic busy, busy_n, step_done, step_done_n, overrun, overrun_n, illegal_move, illegal_move_n;
    logic [31:0] maze [32];
    int total = 0, passed = 0;
    vec_t vt [15];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= maze[mem_addr];
        if (mem_rd_n) mem_rdata_n <= maze[mem_addr_n];
    end

    ghost_step_ctrl dut (
        .clk(clk), .reset(reset), .move_tick(move_tick), .load_pos(load_pos), .load_val(load_val),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .nbr_rows(nbr_rows),
        .nbr_valid(nbr_valid), .next_pos_in(next_pos_in), .ghost_pos(ghost_pos), .busy(busy),
        .step_done(step_done), .overrun(overrun), .illegal_move(illegal_move)
    );

    ghost_step_ctrl #(.CHECK_MOVES(1'b0)) dut_n (
        .clk(clk), .reset(reset), .move_tick(move_tick), .load_pos(load_pos), .load_val(load_val),
        .mem_rd(mem_rd_n), .mem_addr(mem_addr_n), .mem_rdata(mem_rdata_n), .nbr_rows(nbr_rows_n),
        .nbr_valid(nbr_valid_n), .next_pos_in(next_pos_in), .ghost_pos(ghost_pos_n), .busy(busy_n),
        .step_done(step_done_n), .overrun(overrun_n), .illegal_move(illegal_move_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        move_tick = 1'b0;
        load_pos = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic load(input pos_t v);
        load_pos = 1'b1;
        load_val = v;
        cyc();
        load_pos = 1'b0;
    endtask

    task automatic clear_maze();
        foreach (maze[i]) maze[i] = '0;
    endtask

    // Ticks in cycle 0 and checks the strobes of cycles 0..5; returns at the start of cycle 6.
    task automatic run_step(input pos_t np, input coord_t r);
        coord_t ea;
        next_pos_in = np;
        move_tick = 1'b1;
        @(negedge clk);
        chk("busy_c0", {31'b0, busy}, 0);
        cyc();
        move_tick = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ea = r + 5'(c) - 5'd2;
            if (c <= 3) chk($sformatf("addr_c%0d", c), {27'b0, mem_addr}, {27'b0, ea});
            chk($sformatf("rd_c%0d", c), {31'b0, mem_rd}, (c <= 3) ? 1 : 0);
            chk($sformatf("done_c%0d", c), {31'b0, step_done}, (c == 5) ? 1 : 0);
            chk($sformatf("valid_c%0d", c), {31'b0, nbr_valid}, (c == 5) ? 1 : 0);
            chk($sformatf("busy_c%0d", c), {31'b0, busy}, 1);
            cyc();
        end
    endtask

    initial begin
        int sd;
        coord_t r;
        vt[0]  = '{10'd367, 10'd368, 32'h0000_000A, 32'h0000_0000, 32'h5000_0000, 10'd368, 1'b0};
        vt[1]  = '{10'd367, 10'd368, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 10'd367, 1'b1};
        vt[2]  = '{10'd367, 10'd335, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 10'd335, 1'b0};
        vt[3]  = '{10'd479, 10'd448, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 10'd448, 1'b0};
        vt[4]  = '{10'd0,   10'd992, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 10'd992, 1'b0};
        vt[5]  = '{10'd367, 10'd369, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 10'd367, 1'b1};
        vt[6]  = '{10'd367, 10'd367, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10'd367, 1'b0};
        vt[7]  = '{10'd367, 10'd399, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000, 10'd367, 1'b1};
        vt[8]  = '{10'd367, 10'd366, 32'h0000_0000, 32'h0000_4000, 32'h0000_0000, 10'd367, 1'b1};
        vt[9]  = '{10'd367, 10'd366, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 10'd366, 1'b0};
        vt[10] = '{10'd367, 10'd335, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 10'd367, 1'b1};
        vt[11] = '{10'd367, 10'd336, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 10'd367, 1'b1};
        vt[12] = '{10'd0,   10'd31,  32'h0000_0000, 32'h0000_0002, 32'h0000_0000, 10'd31,  1'b0};
        vt[13] = '{10'd992, 10'd0,   32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 10'd992, 1'b1};
        vt[14] = '{10'd367, 10'd368, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 10'd368, 1'b0};

        clear_maze();
        do_reset();
        @(negedge clk);
        chk("rst_pos", {22'b0, ghost_pos}, 367);
        chk("rst_rows_zero", {31'b0, nbr_rows == '0}, 1);
        chk("rst_flags", {26'b0, nbr_valid, busy, step_done, mem_rd, overrun, illegal_move}, 0);
        chk("rst_addr", {27'b0, mem_addr}, 0);
        cyc();

        foreach (vt[i]) begin
            do_reset();
            clear_maze();
            r = pos_row(vt[i].start);
            maze[r - 5'd1] = vt[i].up_w;
            maze[r] = vt[i].cur_w;
            maze[r + 5'd1] = vt[i].dn_w;
            load(vt[i].start);
            run_step(vt[i].np, r);
            @(negedge clk);
            chk($sformatf("v%0d_pos", i), {22'b0, ghost_pos}, {22'b0, vt[i].exp_pos});
            chk($sformatf("v%0d_illegal", i), {31'b0, illegal_move}, {31'b0, vt[i].exp_ill});
            chk($sformatf("v%0d_row_up", i), nbr_rows[0], vt[i].up_w);
            chk($sformatf("v%0d_row_dn", i), nbr_rows[1], vt[i].dn_w);
            chk($sformatf("v%0d_row_l", i), nbr_rows[2], vt[i].cur_w);
            chk($sformatf("v%0d_row_r", i), nbr_rows[3], vt[i].cur_w);
            chk($sformatf("v%0d_busy_c6", i), {31'b0, busy}, 0);
            chk($sformatf("v%0d_nochk_pos", i), {22'b0, ghost_pos_n}, {22'b0, vt[i].np});
            chk($sformatf("v%0d_nochk_illegal", i), {31'b0, illegal_move_n}, 0);
            cyc();
        end

        // second tick lands in cycle 3
        do_reset();
        clear_maze();
        next_pos_in = 10'd368;
        sd = 0;
        for (int c = 0; c <= 7; c++) begin
            move_tick = (c == 0 || c == 3);
            @(negedge clk);
            if (c == 2) chk("ovr_before", {31'b0, overrun}, 0);
            if (step_done) sd++;
            cyc();
        end
        move_tick = 1'b0;
        @(negedge clk);
        chk("ovr_flag", {31'b0, overrun}, 1);
        chk("ovr_done_cnt", sd, 1);
        chk("ovr_pos", {22'b0, ghost_pos}, 368);
        cyc();

        // load in cycle 3 aborts the step
        do_reset();
        next_pos_in = 10'd368;
        sd = 0;
        for (int c = 0; c <= 8; c++) begin
            move_tick = (c == 0);
            load_pos = (c == 3);
            load_val = 10'd100;
            @(negedge clk);
            if (c == 4) begin
                chk("ld_pos_c4", {22'b0, ghost_pos}, 100);
                chk("ld_busy_c4", {31'b0, busy}, 0);
                chk("ld_valid_c4", {31'b0, nbr_valid}, 0);
            end
            if (step_done) sd++;
            cyc();
        end
        load_pos = 1'b0;
        @(negedge clk);
        chk("ld_done_cnt", sd, 0);
        chk("ld_pos_end", {22'b0, ghost_pos}, 100);
        chk("ld_overrun", {31'b0, overrun}, 0);
        cyc();

        // load and tick together in IDLE: load wins, no overrun, no step
        do_reset();
        sd = 0;
        move_tick = 1'b1;
        load_pos = 1'b1;
        load_val = 10'd200;
        cyc();
        move_tick = 1'b0;
        load_pos = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) chk("lt_busy", {31'b0, busy}, 0);
            if (step_done) sd++;
            cyc();
        end
        @(negedge clk);
        chk("lt_pos", {22'b0, ghost_pos}, 200);
        chk("lt_overrun", {31'b0, overrun}, 0);
        chk("lt_done_cnt", sd, 0);
        cyc();

        // reset in cycle 4 after flags were made sticky
        do_reset();
        clear_maze();
        maze[11] = 32'h0001_0000;
        run_step(10'd368, 5'd11);
        @(negedge clk);
        chk("rs_illegal_set", {31'b0, illegal_move}, 1);
        cyc();
        sd = 0;
        for (int c = 0; c <= 6; c++) begin
            move_tick = (c == 0 || c == 2);
            reset = (c == 4);
            @(negedge clk);
            if (c == 3) chk("rs_ovr_set", {31'b0, overrun}, 1);
            if (c == 5) begin
                chk("rs_pos", {22'b0, ghost_pos}, 367);
                chk("rs_flags", {26'b0, nbr_valid, busy, step_done, mem_rd, overrun, illegal_move}, 0);
                chk("rs_rows_zero", {31'b0, nbr_rows == '0}, 1);
                chk("rs_addr", {27'b0, mem_addr}, 0);
            end
            if (c >= 1 && step_done) sd++;
            cyc();
        end
        move_tick = 1'b0;
        reset = 1'b0;
        chk("rs_done_cnt", sd, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
